// File: rtl/spine_pkg.sv
// rtl/spine_pkg.sv - shared widths, port limits, FSM encoding and address helpers for the spine ingress stage
// Contents:
//   ADDR_W, PORT_W           destination address / output port widths
//   PORT_INVALID, PORT_MAX   routing-table result limits (valid ports are 0001..1011)
//   state_e                  ingress FSM states
//   get_group_id/get_leaf_id split a dest address into {GroupID, LeafID}
//   port_is_valid            true for a routable output port
package spine_pkg;

  localparam int ADDR_W = 6;
  localparam int PORT_W = 4;

  localparam logic [PORT_W-1:0] PORT_INVALID = 4'b0000;
  localparam logic [PORT_W-1:0] PORT_MAX     = 4'b1011;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ROUTE = 3'd1,
    ST_REQ   = 3'd2,
    ST_XFER  = 3'd3,
    ST_DROP  = 3'd4
  } state_e;

  function automatic logic [3:0] get_group_id(input logic [ADDR_W-1:0] addr);
    return addr[5:2];
  endfunction

  function automatic logic [1:0] get_leaf_id(input logic [ADDR_W-1:0] addr);
    return addr[1:0];
  endfunction

  function automatic logic port_is_valid(input logic [PORT_W-1:0] port);
    return (port != PORT_INVALID) && (port <= PORT_MAX);
  endfunction

endpackage

// File: rtl/spine_flit_fifo.sv
// rtl/spine_flit_fifo.sv - ingress flit buffer (data plus last bit) with full/empty flags
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (empties the buffer)
//   push_i       write wdata_i; ignored while full (no write-through)
//   wdata_i      {last, data}
//   pop_i        drop the head entry; ignored while empty
//   rdata_o      head entry, valid when empty_o = 0
//   full_o       DEPTH entries held
//   empty_o      no entries held
module spine_flit_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/spine_ingress_route_stage.sv
// rtl/spine_ingress_route_stage.sv - spine input port: buffer flits, route head, request allocator, stream or drop
// Optional statistics (drop_cnt, pkt_cnt) are built only when SPINE_ING_STATS_EN is defined.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last   upstream flit stream
//   rt_dest_addr, rt_out_port       routing-table lookup (address out, port back)
//   sa_req, sa_req_port, sa_grant   switch-allocator handshake
//   out_valid/out_ready/out_data/out_last  crossbar flit stream
//   drop_cnt, pkt_cnt               saturating packet counters (SPINE_ING_STATS_EN only)
module spine_ingress_route_stage
  import spine_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_LSB   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic [ADDR_W-1:0] rt_dest_addr,
  input  logic [PORT_W-1:0] rt_out_port,
  output logic              sa_req,
  output logic [PORT_W-1:0] sa_req_port,
  input  logic              sa_grant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
`ifdef SPINE_ING_STATS_EN
  ,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       pkt_cnt
`endif
);

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [DATA_W:0]   fifo_head;
  logic [DATA_W-1:0] head_data;
  logic              head_last;
  logic [ADDR_W-1:0] head_addr;
  state_e            state_q, state_d;
  logic [PORT_W-1:0] port_q, port_d;

  spine_flit_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid),
    .wdata_i ({in_last, in_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_data = fifo_head[DATA_W-1:0];
  assign head_last = fifo_head[DATA_W];
  assign head_addr = head_data[ADDR_LSB +: ADDR_W];

  // Gated by rst_n so in_ready reads 0 while reset is held.
  assign in_ready     = rst_n && !fifo_full;
  assign rt_dest_addr = fifo_empty ? '0 : {get_group_id(head_addr), get_leaf_id(head_addr)};

  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    sa_req    = 1'b0;
    out_valid = 1'b0;
    fifo_pop  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_ROUTE;
      end
      ST_ROUTE: begin
        port_d  = rt_out_port;
        state_d = port_is_valid(rt_out_port) ? ST_REQ : ST_DROP;
      end
      ST_REQ: begin
        sa_req = 1'b1;
        if (sa_grant) state_d = ST_XFER;
      end
      ST_XFER: begin
        // Request stays up for the whole packet: the grant holds the crossbar path.
        sa_req    = 1'b1;
        out_valid = !fifo_empty;
        fifo_pop  = out_valid && out_ready;
        if (fifo_pop && head_last) state_d = ST_IDLE;
      end
      ST_DROP: begin
        fifo_pop = !fifo_empty;
        if (fifo_pop && head_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sa_req_port = sa_req ? port_q : '0;
  assign out_data    = out_valid ? head_data : '0;
  assign out_last    = out_valid && head_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      port_q  <= PORT_INVALID;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
    end
  end

`ifdef SPINE_ING_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (fifo_pop && head_last) begin
      if (state_q == ST_XFER && pkt_cnt_q != 16'hFFFF) pkt_cnt_d = pkt_cnt_q + 16'd1;
      if (state_q == ST_DROP && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_spine_ingress_route_stage.sv
// tb/tb_spine_ingress_route_stage.sv - randomized self-checking bench for spine_ingress_route_stage
module tb_spine_ingress_route_stage;

  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_LSB   = 0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic [5:0]        rt_dest_addr;
  logic [3:0]        rt_out_port;
  logic              sa_req;
  logic [3:0]        sa_req_port;
  logic              sa_grant = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
`ifdef SPINE_ING_STATS_EN
  logic [15:0]       drop_cnt;
  logic [15:0]       pkt_cnt;
`endif

  spine_ingress_route_stage #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_LSB   (ADDR_LSB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .rt_dest_addr (rt_dest_addr),
    .rt_out_port  (rt_out_port),
    .sa_req       (sa_req),
    .sa_req_port  (sa_req_port),
    .sa_grant     (sa_grant),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last)
`ifdef SPINE_ING_STATS_EN
    ,
    .drop_cnt     (drop_cnt),
    .pkt_cnt      (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Routing table for a spine whose own group is 0111: local leaves map to
  // ports 1..4, other groups to uplinks; groups 9..12 return out-of-range
  // ports (>1011) and groups 0, 13..15 return the invalid port.
  function automatic logic [3:0] rt_lookup(input logic [5:0] a);
    int g;
    int l;
    g = int'(a[5:2]);
    l = int'(a[1:0]);
    if (g == 7) return 4'(l + 1);
    if (g >= 1 && g <= 6) return 4'(g + 4);
    if (g >= 8 && g <= 12) return 4'(g + 3);
    return 4'b0000;
  endfunction

  assign rt_out_port = rt_lookup(rt_dest_addr);

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              l;
  } flit_t;

  flit_t           src_q[$];
  logic [DATA_W:0] exp_flits[$];
  logic [3:0]      exp_ports[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_out = 0;
  int exp_pkt = 0;
  int exp_drop = 0;
  int grant_mode = 1;   // 0 random, 1 always, 2 never
  int ready_mode = 0;   // 0 always, 1 random, 2 toggle
  int gap_pct = 0;
  int t_head = 0;
  int t_ov = 0;
  bit ov_seen = 1'b0;
  bit in_pkt = 1'b0;
  bit cur_fwd = 1'b0;
  bit acc = 1'b0;
  bit tail_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a packet's fate is decided from its head address alone.
  task automatic model_accept(input flit_t f);
    logic [3:0] p;
    if (!in_pkt) begin
      p       = rt_lookup(f.d[ADDR_LSB +: 6]);
      cur_fwd = (p >= 4'd1 && p <= 4'd11);
      if (cur_fwd) exp_ports.push_back(p);
      in_pkt  = 1'b1;
      t_head  = cyc;
      ov_seen = 1'b0;
    end
    if (cur_fwd) exp_flits.push_back({f.l, f.d});
    if (f.l) begin
      in_pkt = 1'b0;
      if (cur_fwd) exp_pkt++;
      else exp_drop++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (acc) begin
      in_valid = 1'b0;
      acc      = 1'b0;
    end
    if (!in_valid && src_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
      in_valid = 1'b1;
      in_data  = src_q[0].d;
      in_last  = src_q[0].l;
    end
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = ~out_ready;
    endcase
    case (grant_mode)
      0: sa_grant = ($urandom_range(0, 2) == 0);
      1: sa_grant = 1'b1;
      default: sa_grant = 1'b0;
    endcase
    #1;
    if (tail_prev) begin
      check("bubble_sa_req", sa_req, 1'b0);
      check("bubble_out_valid", out_valid, 1'b0);
    end
    tail_prev = 1'b0;
    if (sa_req) begin
      if (exp_ports.size() == 0) check("sa_req_unexpected", sa_req, 1'b0);
      else check("sa_req_port", sa_req_port, exp_ports[0]);
    end
    if (out_valid) begin
      check("out_valid_without_req", sa_req, 1'b1);
      if (!ov_seen) begin
        ov_seen = 1'b1;
        t_ov    = cyc;
      end
    end
    if (out_valid && out_ready) begin
      if (exp_flits.size() == 0) check("flit_unexpected", out_valid, 1'b0);
      else check("flit", {out_last, out_data}, exp_flits.pop_front());
      if (out_last) begin
        tail_prev = 1'b1;
        if (exp_ports.size() > 0) void'(exp_ports.pop_front());
      end
      n_out++;
    end
    if (in_valid && in_ready) begin
      acc = 1'b1;
      model_accept(src_q.pop_front());
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef SPINE_ING_STATS_EN
    check({tag, "_pkt_cnt"}, pkt_cnt, 16'(exp_pkt));
    check({tag, "_drop_cnt"}, drop_cnt, 16'(exp_drop));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((src_q.size() > 0 || exp_flits.size() > 0 || in_pkt) && n < 3000) begin
      step();
      n++;
    end
    check({tag, "_drained"}, 64'(src_q.size() + exp_flits.size()), 64'd0);
    repeat (10) step();
    check_stats(tag);
  endtask

  task automatic send_pkt(input logic [5:0] addr, input int len);
    flit_t f;
    for (int i = 0; i < len; i++) begin
      f.d = $urandom();
      if (i == 0) f.d[ADDR_LSB +: 6] = addr;
      f.l = (i == len - 1);
      src_q.push_back(f);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_out_last"}, out_last, 1'b0);
    check({tag, "_sa_req"}, sa_req, 1'b0);
    check({tag, "_sa_req_port"}, sa_req_port, 4'd0);
    check({tag, "_rt_dest_addr"}, rt_dest_addr, 6'd0);
    check_stats(tag);
  endtask

  initial begin
    flit_t f;
    int    base;
    int    n;

    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single-flit packet, grant available immediately.
    grant_mode = 1;
    ready_mode = 0;
    f.d = 32'h0000001D;
    f.l = 1'b1;
    src_q.push_back(f);
    drain("single");
    check("single_latency", 64'(t_ov - t_head), 64'd4);

    // Grant withheld: FIFO fills behind a 4-flit packet.
    grant_mode = 2;
    send_pkt(6'h05, 4);
    send_pkt(6'h1D, 2);
    repeat (10) step();
    check("fill_in_ready", in_ready, 1'b0);
    check("fill_sa_req", sa_req, 1'b1);
    check("fill_sa_req_port", sa_req_port, 4'b0101);
    grant_mode = 1;
    ready_mode = 2;
    drain("fill");

    // Invalid destinations are dropped; grant pulses during DROP are ignored.
    ready_mode = 0;
    send_pkt(6'h00, 3);
    drain("drop0");
    send_pkt(6'h3C, 3);
    drain("drop15");
    send_pkt(6'h24, 2);
    drain("drop_over_max");

    // Back-to-back packets to ports 0100 then 1011.
    send_pkt(6'h1F, 2);
    send_pkt(6'h21, 2);
    drain("b2b");

    // Grant while idle must not start a transfer.
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_grant_out_valid", out_valid, 1'b0);
      check("idle_grant_sa_req", sa_req, 1'b0);
    end

    // Reset during flit 2 of a 4-flit packet.
    send_pkt(6'h1F, 4);
    base = n_out;
    n = 0;
    while (n_out == base && n < 50) begin
      step();
      n++;
    end
    check("rst_reach_xfer", 64'(n_out - base), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    src_q.delete();
    exp_flits.delete();
    exp_ports.delete();
    in_valid  = 1'b0;
    acc       = 1'b0;
    in_pkt    = 1'b0;
    tail_prev = 1'b0;
    exp_pkt   = 0;
    exp_drop  = 0;
    check_zero("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    send_pkt(6'h21, 1);
    drain("post_rst");

    // Randomized traffic.
    grant_mode = 0;
    ready_mode = 1;
    gap_pct    = 30;
    for (int i = 0; i < 40; i++) begin
      send_pkt(6'($urandom_range(0, 63)), $urandom_range(1, 5));
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
